// File: rtl/lfsr_rand_arbiter.sv
// Round-robin arbiter sharing one free-running XNOR LFSR sampler among NUM_REQ requesters.
// Each grant captures LFSR samples, rejects out-of-range values, and falls back to RANGE_MAX.
module lfsr_rand_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned RANGE_MAX = 1000,
    parameter int unsigned MAX_RETRY = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   lfsr_out,
    output logic               lfsr_enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [WIDTH-1:0]   rand_val,
    output logic               rand_valid,
    output logic               rand_clamped,
    output logic               busy
);

    localparam int unsigned     PtrW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_REQ - 1);

    typedef enum logic [1:0] {StIdle, StCapture, StCheck, StDeliver} state_e;

    state_e           state_q;
    logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]  winner_q, winner_d;
    logic [PtrW-1:0]  idx;
    logic [3:0]       retry_q;
    logic [WIDTH-1:0] rand_val_q;
    logic             rand_clamped_q;
    logic             found;
    logic             reject;

    // First requester at or above rr_ptr_q, wrapping around.
    always_comb begin
        winner_d = '0;
        found    = 1'b0;
        idx      = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[idx]) begin
                found    = 1'b1;
                winner_d = idx;
            end
            idx = (idx == LastIdx) ? '0 : idx + 1'b1;
        end
    end

    assign rr_ptr_d = (winner_q == LastIdx) ? '0 : winner_q + 1'b1;

    // All-ones is the XNOR lockup state and never a usable sample.
    assign reject = (32'(lfsr_out) > RANGE_MAX) || (&lfsr_out);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            rr_ptr_q       <= '0;
            winner_q       <= '0;
            retry_q        <= '0;
            rand_val_q     <= '0;
            rand_clamped_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        winner_q <= winner_d;
                        retry_q  <= '0;
                        state_q  <= StCapture;
                    end
                end
                StCapture: state_q <= StCheck;
                StCheck: begin
                    if (!reject) begin
                        rand_val_q     <= lfsr_out;
                        rand_clamped_q <= 1'b0;
                        state_q        <= StDeliver;
                    end else if (retry_q < 4'(MAX_RETRY)) begin
                        retry_q <= retry_q + 4'd1;
                        state_q <= StCapture;
                    end else begin
                        rand_val_q     <= WIDTH'(RANGE_MAX);
                        rand_clamped_q <= 1'b1;
                        state_q        <= StDeliver;
                    end
                end
                StDeliver: begin
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Strobes decode straight from the state register.
    assign lfsr_enable  = (state_q == StCapture);
    assign busy         = (state_q != StIdle);
    assign rand_valid   = (state_q == StDeliver);
    assign gnt          = rand_valid ? (NUM_REQ'(1) << winner_q) : '0;
    assign rand_val     = rand_val_q;
    assign rand_clamped = rand_clamped_q;

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Scoreboard bench for lfsr_rand_arbiter: a reference model predicts grant order, sample
// consumption and delivered value; a monitor checks each delivery as it appears.
module tb_lfsr_rand_arbiter;

    localparam int unsigned NumReq   = 4;
    localparam int unsigned Width    = 10;
    localparam int unsigned RangeMax = 1000;
    localparam int unsigned MaxRetry = 7;

    logic              clk      = 1'b0;
    logic              reset_n  = 1'b0;
    logic [NumReq-1:0] req      = '0;
    logic [Width-1:0]  lfsr_out = '0;
    logic              lfsr_enable;
    logic [NumReq-1:0] gnt;
    logic [Width-1:0]  rand_val;
    logic              rand_valid;
    logic              rand_clamped;
    logic              busy;

    typedef struct {
        logic [NumReq-1:0] g;
        int unsigned       val;
        bit                cl;
        int unsigned       n;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned src_q[$];
    int unsigned stage[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int unsigned cyc    = 0;
    int unsigned t_ref  = 0;
    int unsigned en_cnt = 0;
    int unsigned m_rr   = 0;

    lfsr_rand_arbiter #(
        .NUM_REQ  (NumReq),
        .WIDTH    (Width),
        .RANGE_MAX(RangeMax),
        .MAX_RETRY(MaxRetry)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .lfsr_out    (lfsr_out),
        .lfsr_enable (lfsr_enable),
        .gnt         (gnt),
        .rand_val    (rand_val),
        .rand_valid  (rand_valid),
        .rand_clamped(rand_clamped),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Requesters drop their bit as soon as they see their grant.
    task automatic tick();
        @(negedge clk);
        req = req & ~gnt;
    endtask

    function automatic int unsigned pick(input int unsigned mask);
        for (int i = 0; i < NumReq; i++) begin
            int unsigned k;
            k = (m_rr + i) % NumReq;
            if (mask[k]) return k;
        end
        return 0;
    endfunction

    // Consume staged samples the way the block should: first acceptable one wins,
    // otherwise MaxRetry+1 rejections yield the clamped fallback.
    task automatic plan_txn(input int unsigned w);
        exp_t        e;
        int unsigned v;
        e.g   = NumReq'(1) << w;
        e.val = RangeMax;
        e.cl  = 1'b1;
        e.n   = 0;
        while (e.n < MaxRetry + 1 && e.n < stage.size()) begin
            v = stage[e.n];
            src_q.push_back(v);
            e.n++;
            if (v <= RangeMax && v != (1 << Width) - 1) begin
                e.val = v;
                e.cl  = 1'b0;
                break;
            end
        end
        exp_q.push_back(e);
        stage.delete();
        m_rr = (w + 1) % NumReq;
    endtask

    task automatic stage_rand(input bit mixed);
        int unsigned kind;
        kind = mixed ? $urandom_range(0, 9) : 9;
        if (kind == 0) begin
            repeat (MaxRetry + 1) stage.push_back($urandom_range(RangeMax + 1, 1023));
        end else begin
            if (kind <= 4) repeat ($urandom_range(1, 4)) stage.push_back($urandom_range(1001, 1023));
            stage.push_back(($urandom_range(0, 7) == 0) ? RangeMax : $urandom_range(0, RangeMax));
        end
    endtask

    task automatic wait_idle();
        int unsigned b;
        b = 0;
        while (exp_q.size() != 0 && b < 400) begin
            tick();
            b++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: %0d deliveries outstanding, required 0", exp_q.size());
            exp_q.delete();
            src_q.delete();
            req = '0;
        end
        repeat (2) tick();
    endtask

    task automatic batch(input int unsigned mask, input bit mixed);
        int unsigned rem, w;
        rem = mask;
        while (rem != 0) begin
            w = pick(rem);
            stage_rand(mixed);
            plan_txn(w);
            rem = rem & ~(32'd1 << w);
        end
        req   = NumReq'(mask);
        t_ref = cyc;
        wait_idle();
    endtask

    // LFSR model: presents the next planned sample after each capture pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && lfsr_enable) begin
                en_cnt++;
                if (src_q.size() != 0) begin
                    lfsr_out = Width'(src_q.pop_front());
                end else begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL lfsr_enable: unplanned capture pulse at cycle %0d, required none", cyc);
                    lfsr_out = '0;
                end
            end
        end
    end

    // Monitor: pops one expectation per delivery strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("gnt_vs_valid", 32'(gnt != '0), 32'(rand_valid));
                if (rand_valid) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL delivery: unexpected gnt=%b val=%0d, required none", gnt, rand_val);
                    end else begin
                        e = exp_q.pop_front();
                        check("gnt", 32'(gnt), 32'(e.g));
                        check("rand_val", 32'(rand_val), e.val);
                        check("rand_clamped", 32'(rand_clamped), 32'(e.cl));
                        check("enable_pulses", en_cnt, e.n);
                        check("latency", cyc - t_ref, 2 * e.n + 1);
                    end
                    en_cnt = 0;
                    t_ref  = cyc + 1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_valid", 32'(rand_valid), 0);
        check("rst_enable", 32'(lfsr_enable), 0);
        check("rst_val", 32'(rand_val), 0);
        check("rst_clamped", 32'(rand_clamped), 0);
        reset_n = 1'b1;
        tick();

        // Single request, exact cycle-by-cycle timing
        stage.push_back(201);
        plan_txn(0);
        req   = 4'b0001;
        t_ref = cyc;
        for (int k = 0; k < 5; k++) begin
            check("t1_enable", 32'(lfsr_enable), 32'(k == 1));
            check("t1_busy", 32'(busy), 32'(k >= 1 && k <= 3));
            tick();
        end
        check("t1_val_hold", 32'(rand_val), 201);
        wait_idle();

        // Range boundary: just above rejected, exactly RANGE_MAX accepted
        stage.push_back(RangeMax + 1);
        stage.push_back(RangeMax);
        plan_txn(pick(4'b0010));
        req   = 4'b0010;
        t_ref = cyc;
        wait_idle();

        // Asynchronous reset while in CHECK
        src_q.push_back(55);
        req = 4'b0001;
        tick();
        tick();
        check("t5_in_check", 32'(busy), 1);
        #1 reset_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_gnt", 32'(gnt), 0);
        check("t5_valid", 32'(rand_valid), 0);
        check("t5_enable", 32'(lfsr_enable), 0);
        req  = '0;
        m_rr = 0;
        tick();
        tick();
        en_cnt  = 0;
        reset_n = 1'b1;
        repeat (8) begin
            tick();
            check("t5_stays_idle", 32'(busy), 0);
        end

        // Round-robin from a fresh pointer, then a second full round
        batch(4'b1111, 1'b0);
        batch(4'b1111, 1'b0);

        // Rejections then accept
        stage.push_back(1005);
        stage.push_back(1023);
        stage.push_back(17);
        plan_txn(pick(4'b0100));
        req   = 4'b0100;
        t_ref = cyc;
        wait_idle();

        // Every sample rejected: clamped fallback
        repeat (MaxRetry + 1) stage.push_back(1023);
        plan_txn(pick(4'b1000));
        req   = 4'b1000;
        t_ref = cyc;
        wait_idle();

        // Winner drops its request; a new one arrives while busy
        stage.push_back(300);
        plan_txn(2);
        stage.push_back(400);
        plan_txn(1);
        req   = 4'b0100;
        t_ref = cyc;
        tick();
        req[2] = 1'b0;
        tick();
        req[1] = 1'b1;
        wait_idle();

        // Randomized batches with mixed rejection patterns
        repeat (30) batch($urandom_range(1, 15), 1'b1);

        repeat (5) tick();
        check("exp_q_drained", exp_q.size(), 0);
        check("src_q_drained", src_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_rand_arbiter.md
Name: lfsr_rand_arbiter

Overview:
Shares one free-running 10-bit XNOR LFSR sampler among NUM_REQ game-logic requesters, e.g. computer player and target placement.
- Round-robin arbitration between requesters.
- Pulses the LFSR's capture enable once per granted request.
- Range-checks the captured value by rejection sampling and returns it with a one-cycle grant/valid pulse.
- Sits between the LFSR instance and the game FSMs. It is the only driver of the LFSR enable input.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 10, LFSR/random value width
RANGE_MAX, 1000, largest acceptable value; values above it are rejected
MAX_RETRY, 7, rejections allowed before fallback (1..15)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester level request, held until own gnt bit
lfsr_out  input  WIDTH  captured LFSR value; updates the edge after lfsr_enable=1
lfsr_enable  output  1  one-cycle capture pulse to the LFSR
gnt  output  NUM_REQ  one-hot grant, one-cycle pulse, coincident with rand_valid
rand_val  output  WIDTH  delivered random value, valid only when rand_valid=1
rand_valid  output  1  one-cycle delivery strobe
rand_clamped  output  1  with rand_valid: value is the fallback, not a sample
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - rr_ptr=0, retry=0, winner=0.
  - All outputs 0: lfsr_enable, gnt, rand_val, rand_valid, rand_clamped, busy.
  - Reset mid-transaction aborts it; no gnt is issued. The LFSR itself is not reset by this block.
- FSM states: IDLE, CAPTURE, CHECK, DELIVER.
- IDLE:
  - If req!=0, latch winner = first set bit of req searching upward from rr_ptr with wrap. Clear retry. Go to CAPTURE.
  - Otherwise stay in IDLE.
- CAPTURE: lfsr_enable=1 for this cycle only. Go to CHECK.
- CHECK: sample lfsr_out. The value is rejected if lfsr_out > RANGE_MAX or lfsr_out == all-ones (all-ones is the XNOR lockup state).
  - Accepted: register rand_val=lfsr_out, rand_clamped=0. Go to DELIVER.
  - Rejected and retry<MAX_RETRY: retry++. Go to CAPTURE.
  - Rejected and retry==MAX_RETRY: rand_val=RANGE_MAX, rand_clamped=1. Go to DELIVER.
- DELIVER:
  - rand_valid=1 and gnt[winner]=1 for exactly this cycle.
  - rr_ptr = (winner+1) mod NUM_REQ.
  - Go to IDLE unconditionally.
- Latency: req seen in IDLE at cycle 0 gives CAPTURE at cycle 1, CHECK at cycle 2 and rand_valid at cycle 3. Each rejection adds 2 cycles.
- Throughput: at most 1 delivery per 4 cycles. There is always one IDLE cycle between transactions.
- Arbitration timing:
  - Winner is fixed once latched.
  - If the winner drops req mid-transaction, delivery still completes to that winner.
  - Requests arriving while busy wait until IDLE.
- Requester protocol: a requester drops req the cycle after its gnt. If req is still high in the following IDLE, that is a new request.
- rand_val holds its last delivered value between strobes.
- RANGE_MAX >= 2^WIDTH-1: only the all-ones value is rejected.
- RANGE_MAX must be >= 1.
- Outputs are registered. lfsr_enable is decoded from the state register, so it is glitch-free.

Test Plan:
- Reset then single request:
  - Stimulus: reset_n low for 3 cycles, release. req=4'b0001 at cycle 0. LFSR model returns 10'd201.
  - Required: lfsr_enable high exactly at cycle 1. gnt=4'b0001, rand_valid=1, rand_val=201, rand_clamped=0 at cycle 3. busy cycles 1-3.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held, each requester dropping its bit after its grant.
  - Required: grants in order 0001, 0010, 0100, 1000. Next round starts at bit 0. Grants are 4 cycles apart.
- Rejection:
  - Stimulus: model returns 1005, then 1023, then 17.
  - Required: 3 lfsr_enable pulses. rand_val=17 at cycle 7. rand_clamped=0.
- Fallback:
  - Stimulus: model always returns 1023.
  - Required: 8 lfsr_enable pulses. rand_valid with rand_val=1000 and rand_clamped=1 at cycle 17.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 asynchronously in CHECK.
  - Required: busy, gnt, rand_valid and lfsr_enable go 0 immediately. No gnt after release. rr_ptr=0.
- Winner drops request:
  - Stimulus: req=4'b0100 at cycle 0, deasserted at cycle 1. req=4'b0010 asserted at cycle 2.
  - Required: gnt=4'b0100 at cycle 3. gnt=4'b0010 at cycle 7.
